// File: rtl/mux_share_arbiter_pkg.sv
// Shared definitions for the shared-mux round-robin arbiter.
package mux_share_arbiter_pkg;

    localparam int N_DEF        = 8;
    localparam int SELW_DEF     = 3;
    localparam int MAX_HOLD_DEF = 255;
    localparam int CW_DEF       = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux_share_arbiter_if
    import mux_share_arbiter_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int SELW = SELW_DEF
) ();
    logic [N-1:0]    req;
    logic [N-1:0]    din;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic            busy;
    logic            dout;
    logic            timeout;

    modport slave (
        input  req, din,
        output gnt, sel, busy, dout, timeout
    );

    modport master (
        output req, din,
        input  gnt, sel, busy, dout, timeout
    );
endinterface

// File: rtl/mux_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module mux_share_arbiter_rr_pick
    import mux_share_arbiter_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int SELW = SELW_DEF
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] win_o
);
    logic [N-1:0]    rot_s;
    logic [SELW-1:0] off_s;
    logic            found_s;

    // Rotate so that bit 0 of rot_s is the requester just after ptr.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < N; i++) begin
            rot_s[i] = req_i[SELW'((int'(ptr_i) + 1 + i) % N)];
        end
    end

    // Priority-encode the rotated vector; lowest offset wins.
    always_comb begin
        found_s = 1'b0;
        off_s   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            found_s = found_s | rot_s[i];
            off_s   = rot_s[i] ? SELW'(i) : off_s;
        end
    end

    // Un-rotate the offset back to an absolute requester index.
    assign win_o   = SELW'((int'(ptr_i) + 1 + int'(off_s)) % N);
    assign found_o = found_s;

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of one shared 8:1 selection path with a hold-limit preemption.
module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int SELW     = SELW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CW       = CW_DEF
) (
    input logic                clk,
    input logic                rst,
    mux_share_arbiter_if.slave bus
);
    localparam logic [CW-1:0]   MAX_HOLD_C = CW'(MAX_HOLD);
    localparam logic [SELW-1:0] PTR_RST    = SELW'(N - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic            found_s;
    logic [SELW-1:0] win_s;
    logic            owner_req_s;
    logic            others_s;
    logic            limit_hit_s;

    mux_share_arbiter_rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .found_o (found_s),
        .win_o   (win_s)
    );

    // Owner drop takes precedence over the limit, so limit only matters while owner still requests.
    assign owner_req_s = bus.req[sel_q];
    assign others_s    = |(bus.req & ~gnt_q);
    assign limit_hit_s = (MAX_HOLD != 0) && (cnt_q == MAX_HOLD_C) && others_s;

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= PTR_RST;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state decision: every grant returns through IDLE (break-before-make).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s || limit_hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of grant, select, pointer, hold counter and timeout pulse.
    always_comb begin
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    gnt_d        = '0;
                    gnt_d[win_s] = 1'b1;
                    sel_d        = win_s;
                    ptr_d        = win_s;
                    cnt_d        = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    gnt_d = '0;
                end else if (limit_hit_s) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (cnt_q != MAX_HOLD_C) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        busy_d = |gnt_d;
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
    assign bus.dout    = busy_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench: two arbiters (hold limit 4 and limit disabled) driven in lockstep.
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_s;
    logic [7:0] din_s;

    int n_checks;
    int n_fail;

    mux_share_arbiter_if #(.N(8), .SELW(3)) bus4 ();
    mux_share_arbiter_if #(.N(8), .SELW(3)) bus0 ();

    assign bus4.req = req_s;
    assign bus4.din = din_s;
    assign bus0.req = req_s;
    assign bus0.din = din_s;

    mux_share_arbiter #(.N(8), .SELW(3), .MAX_HOLD(4), .CW(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mux_share_arbiter #(.N(8), .SELW(3), .MAX_HOLD(0), .CW(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt4;
        logic       to4;
        logic [7:0] gnt0;
        logic       to0;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt4;
        logic       to4;
        logic [7:0] gnt0;
        logic       to0;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        idx_of = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) idx_of = 3'(i);
        end
    endfunction

    function automatic logic [7:0] oh(input int k);
        logic [7:0] v;
        v = 8'h00;
        v[k % 8] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string tag, input logic [7:0] r, input logic [7:0] d,
                        input logic [7:0] g4, input logic t4,
                        input logic [7:0] g0, input logic t0);
        exp_t e;
        logic [2:0] i4;
        logic [2:0] i0;
        req_s = r;
        din_s = d;
        e.gnt4 = g4; e.to4 = t4; e.gnt0 = g0; e.to0 = t0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        i4 = idx_of(e.gnt4);
        i0 = idx_of(e.gnt0);
        check({tag, ".gnt4"}, bus4.gnt, e.gnt4);
        check({tag, ".busy4"}, 8'(bus4.busy), 8'(|e.gnt4));
        check({tag, ".to4"}, 8'(bus4.timeout), 8'(e.to4));
        check({tag, ".dout4"}, 8'(bus4.dout), 8'((e.gnt4 != 8'h00) ? d[i4] : 1'b0));
        if (e.gnt4 != 8'h00) check({tag, ".sel4"}, 8'(bus4.sel), 8'(i4));
        check({tag, ".gnt0"}, bus0.gnt, e.gnt0);
        check({tag, ".busy0"}, 8'(bus0.busy), 8'(|e.gnt0));
        check({tag, ".to0"}, 8'(bus0.timeout), 8'(e.to0));
        check({tag, ".dout0"}, 8'(bus0.dout), 8'((e.gnt0 != 8'h00) ? d[i0] : 1'b0));
        if (e.gnt0 != 8'h00) check({tag, ".sel0"}, 8'(bus0.sel), 8'(i0));
    endtask

    // Assert reset away from any clock edge and verify outputs clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".gnt4"}, bus4.gnt, 8'h00);
        check({tag, ".sel4"}, 8'(bus4.sel), 8'h00);
        check({tag, ".busy4"}, 8'(bus4.busy), 8'h00);
        check({tag, ".to4"}, 8'(bus4.timeout), 8'h00);
        check({tag, ".gnt0"}, bus0.gnt, 8'h00);
        check({tag, ".sel0"}, 8'(bus0.sel), 8'h00);
        req_s = 8'h00;
        din_s = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req_s    = 8'h00;
        din_s    = 8'h00;

        //          req    din    gnt4   to4   gnt0   to0
        tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{8'h01, 8'h01, 8'h01, 1'b0, 8'h01, 1'b0};
        tbl[2] = '{8'h01, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0};
        tbl[3] = '{8'h00, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h22, 8'h02, 8'h02, 1'b0, 8'h02, 1'b0};
        tbl[5] = '{8'h20, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{8'h20, 8'h20, 8'h20, 1'b0, 8'h20, 1'b0};
        tbl[7] = '{8'h00, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[8] = '{8'h21, 8'hDE, 8'h01, 1'b0, 8'h01, 1'b0};
        tbl[9] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        do_reset("reset0");
        for (int v = 0; v < 10; v++) begin
            step($sformatf("tbl%0d", v), tbl[v].req, tbl[v].din,
                 tbl[v].gnt4, tbl[v].to4, tbl[v].gnt0, tbl[v].to0);
        end

        // All requesting; each owner holds three cycles then drops for one.
        do_reset("reset_rr");
        for (int k = 0; k <= 8; k++) begin
            for (int h = 0; h < 3; h++) begin
                step($sformatf("rr%0d_hold%0d", k, h), 8'hFF, 8'hFF, oh(k), 1'b0, oh(k), 1'b0);
            end
            step($sformatf("rr%0d_drop", k), 8'hFF & ~oh(k), 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
        end

        // Owner 2 held forever, 5 waiting: limit 4 preempts, disabled limit never does.
        do_reset("reset_force");
        step("force_g", 8'h04, 8'hFF, 8'h04, 1'b0, 8'h04, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step($sformatf("force_c%0d", c), 8'h24, 8'hFF, 8'h04, 1'b0, 8'h04, 1'b0);
        end
        step("force_rel", 8'h24, 8'hFF, 8'h00, 1'b1, 8'h04, 1'b0);
        step("force_next", 8'h24, 8'hFF, 8'h20, 1'b0, 8'h04, 1'b0);
        step("force_end", 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);

        // Lone requester saturates the counter without timing out; a late rival then preempts at once.
        do_reset("reset_sat");
        for (int c = 0; c < 20; c++) begin
            step($sformatf("sat%0d", c), 8'h08, 8'h08, 8'h08, 1'b0, 8'h08, 1'b0);
        end
        step("sat_rival", 8'h0A, 8'h08, 8'h00, 1'b1, 8'h08, 1'b0);
        step("sat_next", 8'h0A, 8'h08, 8'h02, 1'b0, 8'h08, 1'b0);
        step("sat_end", 8'h00, 8'h08, 8'h00, 1'b0, 8'h00, 1'b0);

        // Owner drops on the very cycle the limit would fire: normal release, no timeout.
        do_reset("reset_sim");
        for (int c = 0; c <= 4; c++) begin
            step($sformatf("sim%0d", c), 8'h48, 8'h48, 8'h08, 1'b0, 8'h08, 1'b0);
        end
        step("sim_drop", 8'h40, 8'h48, 8'h00, 1'b0, 8'h00, 1'b0);
        step("sim_next", 8'h40, 8'h48, 8'h40, 1'b0, 8'h40, 1'b0);
        step("sim_end", 8'h00, 8'h48, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset mid-grant of owner 4; pointer must return so index 0 wins first.
        do_reset("reset_pre");
        step("mid_g", 8'h10, 8'hFF, 8'h10, 1'b0, 8'h10, 1'b0);
        step("mid_h1", 8'hFF, 8'hFF, 8'h10, 1'b0, 8'h10, 1'b0);
        step("mid_h2", 8'hFF, 8'hFF, 8'h10, 1'b0, 8'h10, 1'b0);
        do_reset("reset_mid");
        step("mid_after", 8'hFF, 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0);
        step("mid_end", 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Round-robin arbiter that shares one 8:1 selection path between up to N requesters. It samples a request vector, grants the path to exactly one requester at a time, and drives the select code and gated data output of the shared mux. A hold-limit counter stops any one requester from monopolising the path. It sits between the requesting logic and the board-level output that the mux drives.

## Interface
- N, 8, number of requesters (2..8)
- SELW, 3, select width; must equal ceil(log2(N))
- MAX_HOLD, 255, maximum GRANT cycles before a forced release when others are waiting; 0 disables the limit
- CW, 8, hold counter width; MAX_HOLD < 2^CW
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N  per-requester request, level; held high for as long as the path is wanted
- din  in  N  per-requester data bit routed to dout while granted
- gnt  out  N  one-hot grant, registered; all zero when idle
- sel  out  SELW  binary index of current owner, registered
- busy  out  1  high while any grant is active (equals OR of gnt)
- dout  out  1  din[sel] when busy, else 0 (combinational from registered sel/busy)
- timeout  out  1  one-cycle pulse on a forced release

## Operation
- States: IDLE, GRANT.
- Reset values: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, hold counter=0, round-robin pointer ptr=N-1. With these values, req[0] has first priority after reset.
- IDLE: if req≠0, pick the first set bit scanning ptr+1, ptr+2, … modulo N. Load gnt/sel with the winner, set ptr=winner, clear the counter, and go to GRANT. If req=0, stay in IDLE.
- GRANT: the owner keeps the path while req[sel]=1.
  - Normal release: when req[sel]=0, go to IDLE with gnt=0.
  - Counter: increments once per GRANT cycle and saturates at MAX_HOLD.
  - Forced release: when MAX_HOLD≠0, the counter equals MAX_HOLD, and any other req bit is set, go to IDLE and pulse timeout. The preempted requester competes normally afterwards; since ptr points at it, it has lowest priority.
  - When the counter is at MAX_HOLD and no other request is pending, the grant is kept and no timeout pulse is produced.
- Requests from indices ≥N do not exist; only in-range indices appear on gnt/sel.
- Invariant: gnt is one-hot or zero at all times, and busy==|gnt.

## Timing
- Grant latency: a req rising before edge t (sampled at t) from IDLE produces gnt/sel/busy valid after edge t.
- Release latency: req[sel] falling, sampled at edge t, clears gnt after edge t. The earliest new grant appears after edge t+1.
- Break-before-make: at least one cycle with gnt=0 always separates two grants. This holds even when another req is continuously high.
- Forced release: the counter reaches MAX_HOLD after MAX_HOLD GRANT cycles. At the next edge gnt clears and timeout=1 for exactly that one cycle.
- Simultaneous events: if the owner drops req on the same cycle the limit fires, this is a normal release and timeout stays 0.
- A req asserted during GRANT by a non-owner is only considered at the next IDLE.
- Reset mid-GRANT: outputs return to reset values asynchronously, and ptr returns to N-1.
- dout follows din combinationally while busy, with no added latency.

## Structure
- Shared package/include: state encodings IDLE/GRANT and the default values of N, SELW, and MAX_HOLD.
- One sub-module, rr_pick. It is purely combinational: inputs req and ptr; outputs a found flag and winner index, using a rotate–priority-encode–unrotate scheme.
- The top level holds the FSM, ptr, the hold counter, the output registers, and the dout mux expression.

## Test plan
- Reset, then req=8'b0000_0001 -> gnt=8'h01, sel=0, busy=1 one cycle after the sample edge; dout tracks din[0]; release -> gnt=0 next cycle.
- req=8'hFF held, MAX_HOLD=0, each owner drops req after 3 cycles then re-raises it -> grant order 0,1,2,…,7,0, with one gnt=0 cycle between grants.
- MAX_HOLD=4, req[2] held forever, req[5] raised -> after 4 GRANT cycles of owner 2, timeout pulses once, gnt=0 for one cycle, then gnt=8'h20.
- MAX_HOLD=4, only req[3] high for 20 cycles -> gnt=8'h08 throughout, timeout never asserts.
- Owner drops req on the same cycle the limit fires, with req[6] pending -> timeout=0 and the next grant goes to 6.
- rst pulsed mid-GRANT of owner 4 with req=8'hFF -> gnt=0, sel=0 immediately; the first grant after reset goes to index 0.
